// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// Shared definitions for the TL-UL LED slave:
//   - A-channel and D-channel opcode constants
//   - register byte offsets within the 16-byte window
//   - register-select and handshake-state enums
//   - lane_hit(): tells whether a data bit falls in an enabled byte lane
// -----------------------------------------------------------------------------
package tlul_pkg;

    // A-channel opcodes
    localparam logic [2:0] A_PUT_FULL    = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] A_GET         = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    // Register byte offsets. Only address bits [3:2] are decoded.
    localparam logic [3:0] OFS_LED   = 4'h0;
    localparam logic [3:0] OFS_CTRL  = 4'h4;
    localparam logic [3:0] OFS_INPUT = 4'h8;

    typedef enum logic [1:0] {
        SEL_LED   = 2'd0,
        SEL_CTRL  = 2'd1,
        SEL_INPUT = 2'd2,
        SEL_NONE  = 2'd3
    } reg_sel_e;

    // Single outstanding transaction: either waiting for a request or
    // presenting a response.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // True when bit bit_idx of the 32-bit data bus lies in an enabled lane.
    function automatic logic lane_hit(input logic [3:0] mask, input int bit_idx);
        logic [31:0] w_idx;
        logic [1:0]  w_lane;
        w_idx  = bit_idx;
        w_lane = w_idx[4:3];
        return mask[w_lane];
    endfunction

endpackage

// File: rtl/tlul_slave_leds_sync.sv
// -----------------------------------------------------------------------------
// tlul_slave_leds_sync
// Two-flop synchronizer for the external switch bank. Both stages clear to 0
// on the synchronous reset.
// Ports:
//   i_clk    clock, rising edge
//   i_reset  synchronous active-high reset
//   i_d      asynchronous input bus (W bits)
//   o_q      synchronized output bus (W bits), two cycles behind i_d
// -----------------------------------------------------------------------------
module tlul_slave_leds_sync #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two-stage shift register; the first stage absorbs metastability.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= {W{1'b0}};
            r_sync <= {W{1'b0}};
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/tlul_slave_leds.sv
// -----------------------------------------------------------------------------
// tlul_slave_leds
// TL-UL leaf slave driving an LED bank. By default the LEDs mirror the switch
// bank; setting CTRL.SW_MODE hands the LEDs to the LED register instead.
//
// Register map (word offset = a_address[3:2]):
//   0x0 LED   RW  LED_W bits
//   0x4 CTRL  RW  bit0 SW_MODE
//   0x8 INPUT RO  sampled i_data
//   0xC       unmapped, d_error=1
//
// Optional build macro: TLUL_SLAVE_LEDS_INPUT_SYNC_EN
//   defined   -> i_data goes through a 2-flop synchronizer (3-cycle passthrough)
//   undefined -> i_data is used directly (1-cycle passthrough)
//
// Ports:
//   i_clk, i_reset            clock and synchronous active-high reset
//   i_data / o_data           switch input / registered LED drive
//   i_a_* / o_a_ready         TL-UL A channel
//   o_d_* / i_d_ready         TL-UL D channel (all D outputs registered)
// -----------------------------------------------------------------------------
module tlul_slave_leds
    import tlul_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 4,
    parameter int LED_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [LED_W-1:0]  i_data,
    output logic [LED_W-1:0]  o_data,
    input  logic              i_a_valid,
    output logic              o_a_ready,
    input  logic [2:0]        i_a_opcode,
    input  logic [1:0]        i_a_size,
    input  logic [SRC_W-1:0]  i_a_source,
    input  logic [ADDR_W-1:0] i_a_address,
    input  logic [3:0]        i_a_mask,
    input  logic [DATA_W-1:0] i_a_data,
    output logic              o_d_valid,
    input  logic              i_d_ready,
    output logic [2:0]        o_d_opcode,
    output logic [1:0]        o_d_size,
    output logic [SRC_W-1:0]  o_d_source,
    output logic [DATA_W-1:0] o_d_data,
    output logic              o_d_error
);

    logic [LED_W-1:0]  w_in;
    logic [LED_W-1:0]  r_led;
    logic              r_sw_mode;
    logic [LED_W-1:0]  r_data;
    state_e            r_state;
    logic              r_a_ready;
    logic              r_d_valid;
    logic [2:0]        r_d_opcode;
    logic [1:0]        r_d_size;
    logic [SRC_W-1:0]  r_d_source;
    logic [DATA_W-1:0] r_d_data;
    logic              r_d_error;

    reg_sel_e          w_sel;
    logic [DATA_W-1:0] w_led_ext;
    logic [DATA_W-1:0] w_in_ext;
    logic [DATA_W-1:0] w_ctrl_ext;
    logic [LED_W-1:0]  w_led_nxt;
    logic [2:0]        w_rsp_opcode;
    logic [DATA_W-1:0] w_rsp_data;
    logic              w_rsp_error;
    logic              w_led_we;
    logic              w_ctrl_we;
    logic              w_accept;
    logic              w_unused_bits;

`ifdef TLUL_SLAVE_LEDS_INPUT_SYNC_EN
    tlul_slave_leds_sync #(
        .W (LED_W)
    ) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_data),
        .o_q     (w_in)
    );
`else
    assign w_in = i_data;
`endif

    // Address bits outside [3:2] and data/mask lanes above LED_W are ignored.
    assign w_unused_bits = ^{i_a_address, i_a_data, i_a_mask};

    // r_a_ready is 0 whenever a response is pending, so this is the handshake.
    assign w_accept = i_a_valid & r_a_ready;

    // Register select from the word offset.
    always_comb begin
        w_sel = SEL_NONE;
        case ({i_a_address[3:2], 2'b00})
            OFS_LED:   w_sel = SEL_LED;
            OFS_CTRL:  w_sel = SEL_CTRL;
            OFS_INPUT: w_sel = SEL_INPUT;
            default:   w_sel = SEL_NONE;
        endcase
    end

    // Zero-extended read views of the registers.
    always_comb begin
        w_led_ext                = {DATA_W{1'b0}};
        w_led_ext[LED_W-1:0]     = r_led;
        w_in_ext                 = {DATA_W{1'b0}};
        w_in_ext[LED_W-1:0]      = w_in;
        w_ctrl_ext               = {DATA_W{1'b0}};
        w_ctrl_ext[0]            = r_sw_mode;
    end

    // Byte-lane merge of write data into the LED register.
    always_comb begin
        w_led_nxt = r_led;
        for (int b = 0; b < LED_W; b++) begin
            if (lane_hit(i_a_mask, b)) begin
                w_led_nxt[b] = i_a_data[b];
            end else begin
                w_led_nxt[b] = r_led[b];
            end
        end
    end

    // Response contents and write enables for the request on the A channel.
    always_comb begin
        w_rsp_opcode = D_ACCESS_ACK;
        w_rsp_data   = {DATA_W{1'b0}};
        w_rsp_error  = 1'b0;
        w_led_we     = 1'b0;
        w_ctrl_we    = 1'b0;
        case (i_a_opcode)
            A_PUT_FULL, A_PUT_PARTIAL: begin
                case (w_sel)
                    SEL_LED:  w_led_we    = 1'b1;
                    SEL_CTRL: w_ctrl_we   = i_a_mask[0];
                    default:  w_rsp_error = 1'b1;
                endcase
            end
            A_GET: begin
                w_rsp_opcode = D_ACCESS_ACK_DATA;
                case (w_sel)
                    SEL_LED:   w_rsp_data  = w_led_ext;
                    SEL_CTRL:  w_rsp_data  = w_ctrl_ext;
                    SEL_INPUT: w_rsp_data  = w_in_ext;
                    default:   w_rsp_error = 1'b1;
                endcase
            end
            default: w_rsp_error = 1'b1;
        endcase
    end

    // LED drive, register writes and the request/response handshake.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_led      <= {LED_W{1'b0}};
            r_sw_mode  <= 1'b0;
            r_data     <= {LED_W{1'b0}};
            r_state    <= ST_IDLE;
            r_a_ready  <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_opcode <= 3'd0;
            r_d_size   <= 2'd0;
            r_d_source <= {SRC_W{1'b0}};
            r_d_data   <= {DATA_W{1'b0}};
            r_d_error  <= 1'b0;
        end else begin
            if (r_sw_mode) begin
                r_data <= r_led;
            end else begin
                r_data <= w_in;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_RESP;
                        r_a_ready  <= 1'b0;
                        r_d_valid  <= 1'b1;
                        r_d_opcode <= w_rsp_opcode;
                        r_d_size   <= i_a_size;
                        r_d_source <= i_a_source;
                        r_d_data   <= w_rsp_data;
                        r_d_error  <= w_rsp_error;
                        if (w_led_we) begin
                            r_led <= w_led_nxt;
                        end
                        if (w_ctrl_we) begin
                            r_sw_mode <= i_a_data[0];
                        end
                    end else begin
                        // First idle cycle after reset raises ready here.
                        r_a_ready <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_d_ready) begin
                        r_state   <= ST_IDLE;
                        r_d_valid <= 1'b0;
                        r_a_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_d_valid <= 1'b0;
                    r_a_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_data     = r_data;
    assign o_a_ready  = r_a_ready;
    assign o_d_valid  = r_d_valid;
    assign o_d_opcode = r_d_opcode;
    assign o_d_size   = r_d_size;
    assign o_d_source = r_d_source;
    assign o_d_data   = r_d_data;
    assign o_d_error  = r_d_error;

endmodule

// File: tb/tb_tlul_slave_leds.sv
// -----------------------------------------------------------------------------
// tb_tlul_slave_leds
// Directed bench for tlul_slave_leds: reset, passthrough, a table of TL-UL
// transactions with hand-computed responses, then hand-written sequences for
// software takeover, D-channel back-pressure and reset during a response.
// -----------------------------------------------------------------------------
module tb_tlul_slave_leds;

`ifdef TLUL_SLAVE_LEDS_INPUT_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [3:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;

    int n_pass  = 0;
    int n_total = 0;

    tlul_slave_leds dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_data      (din),
        .o_data      (dout),
        .i_a_valid   (a_valid),
        .o_a_ready   (a_ready),
        .i_a_opcode  (a_opcode),
        .i_a_size    (a_size),
        .i_a_source  (a_source),
        .i_a_address (a_address),
        .i_a_mask    (a_mask),
        .i_a_data    (a_data),
        .o_d_valid   (d_valid),
        .i_d_ready   (d_ready),
        .o_d_opcode  (d_opcode),
        .o_d_size    (d_size),
        .o_d_source  (d_source),
        .o_d_data    (d_data),
        .o_d_error   (d_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full transaction: request, wait for ready (bounded), capture the
    // response beat, complete the D handshake and confirm the bus is free.
    task automatic do_txn(input logic [2:0] op, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data,
                          input logic [1:0] size, input logic [3:0] src,
                          output logic [2:0] r_op, output logic [31:0] r_data,
                          output logic r_err, output logic [1:0] r_size,
                          output logic [3:0] r_src);
        int cnt;
        @(negedge clk);
        a_valid   = 1'b1;
        a_opcode  = op;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_size    = size;
        a_source  = src;
        cnt = 0;
        while (a_ready !== 1'b1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("a_ready_wait", {31'd0, a_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        chk("d_valid_rsp", {31'd0, d_valid}, 32'd1);
        chk("a_ready_busy", {31'd0, a_ready}, 32'd0);
        r_op   = d_opcode;
        r_data = d_data;
        r_err  = d_error;
        r_size = d_size;
        r_src  = d_source;
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 1'b0;
        chk("d_valid_drop", {31'd0, d_valid}, 32'd0);
        chk("a_ready_back", {31'd0, a_ready}, 32'd1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [3:0]  src;
        logic [7:0]  din;
        logic [2:0]  e_op;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    logic [7:0]  pt_vals [10];
    logic [2:0]  r_op;
    logic [31:0] r_data;
    logic        r_err;
    logic [1:0]  r_size;
    logic [3:0]  r_src;

    initial begin
        // op, addr, mask, wdata, size, src, din | e_op, e_data, e_err
        vt[0]  = '{3'd0, 32'h0000_0000, 4'hF, 32'h0000_00A5, 2'd2, 4'd1,  8'h11, 3'd0, 32'h0000_0000, 1'b0};
        vt[1]  = '{3'd4, 32'h0000_0000, 4'hF, 32'h0000_0000, 2'd2, 4'd2,  8'h22, 3'd1, 32'h0000_00A5, 1'b0};
        vt[2]  = '{3'd1, 32'h0000_0000, 4'h0, 32'h0000_003C, 2'd2, 4'd3,  8'h33, 3'd0, 32'h0000_0000, 1'b0};
        vt[3]  = '{3'd4, 32'h0000_0000, 4'h0, 32'h0000_0000, 2'd2, 4'd4,  8'h44, 3'd1, 32'h0000_00A5, 1'b0};
        vt[4]  = '{3'd1, 32'h0000_0000, 4'hE, 32'h5A5A_5A5A, 2'd2, 4'd5,  8'h55, 3'd0, 32'h0000_0000, 1'b0};
        vt[5]  = '{3'd4, 32'h0000_0000, 4'hF, 32'h0000_0000, 2'd0, 4'd15, 8'h66, 3'd1, 32'h0000_00A5, 1'b0};
        vt[6]  = '{3'd4, 32'h0000_0008, 4'hF, 32'h0000_0000, 2'd2, 4'd6,  8'h3C, 3'd1, 32'h0000_003C, 1'b0};
        vt[7]  = '{3'd4, 32'h0000_000C, 4'hF, 32'h0000_0000, 2'd2, 4'd7,  8'h3C, 3'd1, 32'h0000_0000, 1'b1};
        vt[8]  = '{3'd0, 32'h0000_0008, 4'hF, 32'h0000_00FF, 2'd2, 4'd8,  8'h3C, 3'd0, 32'h0000_0000, 1'b1};
        vt[9]  = '{3'd4, 32'h0000_0008, 4'hF, 32'h0000_0000, 2'd2, 4'd9,  8'h3C, 3'd1, 32'h0000_003C, 1'b0};
        vt[10] = '{3'd2, 32'h0000_0000, 4'hF, 32'h0000_00FF, 2'd2, 4'd10, 8'h77, 3'd0, 32'h0000_0000, 1'b1};
        vt[11] = '{3'd4, 32'h0000_0000, 4'hF, 32'h0000_0000, 2'd2, 4'd11, 8'h88, 3'd1, 32'h0000_00A5, 1'b0};
        vt[12] = '{3'd0, 32'h0000_0004, 4'h1, 32'h0000_0100, 2'd2, 4'd12, 8'h99, 3'd0, 32'h0000_0000, 1'b0};
        vt[13] = '{3'd0, 32'h0000_0004, 4'h2, 32'h0000_0001, 2'd2, 4'd13, 8'hAA, 3'd0, 32'h0000_0000, 1'b0};
        vt[14] = '{3'd4, 32'h1000_0004, 4'hF, 32'h0000_0000, 2'd1, 4'd14, 8'hBB, 3'd1, 32'h0000_0000, 1'b0};
        vt[15] = '{3'd4, 32'h2000_0001, 4'hF, 32'h0000_0000, 2'd2, 4'd0,  8'hCC, 3'd1, 32'h0000_00A5, 1'b0};
        vt[16] = '{3'd0, 32'h0000_001C, 4'hF, 32'h0000_0055, 2'd2, 4'd1,  8'hDD, 3'd0, 32'h0000_0000, 1'b1};

        pt_vals = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12, 8'h01, 8'hFF};

        rst = 1'b1; din = 8'h77; a_valid = 1'b0; a_opcode = 3'd0; a_size = 2'd0;
        a_source = 4'd0; a_address = 32'd0; a_mask = 4'd0; a_data = 32'd0; d_ready = 1'b0;

        // Reset held for two edges, then released.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_o_data", {24'd0, dout}, 32'd0);
        chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_d_error", {31'd0, d_error}, 32'd0);
        chk("rst_d_data", d_data, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel_a_ready", {31'd0, a_ready}, 32'd1);
        chk("rel_d_valid", {31'd0, d_valid}, 32'd0);

        // Passthrough: one value per cycle, expect each LAT edges later.
        for (int k = 0; k < 10 + LAT; k++) begin
            if (k >= LAT) begin
                chk("passthru", {24'd0, dout}, {24'd0, pt_vals[k-LAT]});
            end
            if (k < 10) begin
                din = pt_vals[k];
            end
            @(negedge clk);
        end

        // Transaction table, SW_MODE=0 throughout, so o_data follows din.
        for (int i = 0; i < NV; i++) begin
            din = vt[i].din;
            repeat (LAT + 1) @(negedge clk);
            do_txn(vt[i].op, vt[i].addr, vt[i].mask, vt[i].wdata, vt[i].size, vt[i].src,
                   r_op, r_data, r_err, r_size, r_src);
            chk($sformatf("v%0d_d_opcode", i), {29'd0, r_op}, {29'd0, vt[i].e_op});
            chk($sformatf("v%0d_d_data", i), r_data, vt[i].e_data);
            chk($sformatf("v%0d_d_error", i), {31'd0, r_err}, {31'd0, vt[i].e_err});
            chk($sformatf("v%0d_d_size", i), {30'd0, r_size}, {30'd0, vt[i].size});
            chk($sformatf("v%0d_d_source", i), {28'd0, r_src}, {28'd0, vt[i].src});
            chk($sformatf("v%0d_o_data", i), {24'd0, dout}, {24'd0, vt[i].din});
        end

        // Software takeover: LED holds 0xA5, then SW_MODE is set.
        din = 8'hFF;
        repeat (LAT + 1) @(negedge clk);
        do_txn(3'd0, 32'h4, 4'h1, 32'h1, 2'd2, 4'd3, r_op, r_data, r_err, r_size, r_src);
        chk("swm_put_err", {31'd0, r_err}, 32'd0);
        chk("swm_o_data", {24'd0, dout}, 32'h0000_00A5);
        din = 8'h00;
        repeat (4) @(negedge clk);
        chk("swm_hold", {24'd0, dout}, 32'h0000_00A5);
        do_txn(3'd4, 32'h4, 4'hF, 32'h0, 2'd2, 4'd4, r_op, r_data, r_err, r_size, r_src);
        chk("swm_get_ctrl", r_data, 32'h0000_0001);
        do_txn(3'd1, 32'h0, 4'h1, 32'h0000_FF3C, 2'd2, 4'd5, r_op, r_data, r_err, r_size, r_src);
        chk("swm_led_upd", {24'd0, dout}, 32'h0000_003C);

        // Back-pressure: response held for three cycles with d_ready low.
        @(negedge clk);
        a_valid = 1'b1; a_opcode = 3'd4; a_address = 32'h0; a_mask = 4'hF;
        a_size = 2'd2; a_source = 4'd7; a_data = 32'h0;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stall_d_valid", {31'd0, d_valid}, 32'd1);
            chk("stall_d_data", d_data, 32'h0000_003C);
            chk("stall_d_opcode", {29'd0, d_opcode}, 32'd1);
            chk("stall_d_source", {28'd0, d_source}, 32'd7);
            chk("stall_a_ready", {31'd0, a_ready}, 32'd0);
            @(negedge clk);
        end
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 1'b0;
        chk("stall_rel_d_valid", {31'd0, d_valid}, 32'd0);
        chk("stall_rel_a_ready", {31'd0, a_ready}, 32'd1);

        // Reset while a response is pending.
        a_valid = 1'b1; a_opcode = 3'd4; a_address = 32'h0; a_source = 4'd9;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        chk("mid_d_valid", {31'd0, d_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_d_valid", {31'd0, d_valid}, 32'd0);
        chk("mid_rst_a_ready", {31'd0, a_ready}, 32'd0);
        chk("mid_rst_o_data", {24'd0, dout}, 32'd0);
        rst = 1'b0;
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 1'b0;
        chk("mid_rel_d_valid", {31'd0, d_valid}, 32'd0);
        chk("mid_rel_a_ready", {31'd0, a_ready}, 32'd1);
        do_txn(3'd4, 32'h4, 4'hF, 32'h0, 2'd2, 4'd1, r_op, r_data, r_err, r_size, r_src);
        chk("mid_ctrl_clear", r_data, 32'd0);
        do_txn(3'd4, 32'h0, 4'hF, 32'h0, 2'd2, 4'd2, r_op, r_data, r_err, r_size, r_src);
        chk("mid_led_clear", r_data, 32'd0);
        din = 8'h5E;
        repeat (LAT + 1) @(negedge clk);
        chk("mid_passthru", {24'd0, dout}, 32'h0000_005E);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tlul_slave_leds.md
Name: tlul_slave_leds

Overview:
- TileLink-UL (TL-UL) slave peripheral driving an 8-bit LED bank (o_data) and sampling an 8-bit switch/input bank (i_data).
- Default mode is passthrough: LEDs mirror i_data with fixed latency.
- Software may take over the LEDs through a TL-UL register write.
- Sits on the SoC peripheral crossbar as a leaf slave.

Parameters:
- ADDR_W, 32, TL-UL a_address width.
- DATA_W, 32, TL-UL data bus width (fixed 32; mask is 4 bits).
- SRC_W, 4, a_source/d_source width.
- LED_W, 8, width of i_data/o_data (1..32).

Ports:
- i_clk  in  1  sole clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_data  in  LED_W  external switch/input bank.
- o_data  out  LED_W  LED drive, registered.
- i_a_valid  in  1  A-channel request valid.
- o_a_ready  out  1  A-channel ready.
- i_a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
- i_a_size  in  2  log2 bytes; echoed on d_size.
- i_a_source  in  SRC_W  request ID; echoed on d_source.
- i_a_address  in  ADDR_W  byte address; bits [3:2] decoded.
- i_a_mask  in  4  byte enables.
- i_a_data  in  DATA_W  write data.
- o_d_valid  out  1  D-channel response valid.
- i_d_ready  in  1  D-channel ready.
- o_d_opcode  out  3  0=AccessAck, 1=AccessAckData.
- o_d_size  out  2  echoed a_size.
- o_d_source  out  SRC_W  echoed a_source.
- o_d_data  out  DATA_W  read data; 0 for writes/errors.
- o_d_error  out  1  error flag.

Behaviour:
- Register map (word offset = a_address[3:2]):
  - 0x0 LED: RW, LED_W bits, reset 0.
  - 0x4 CTRL: bit0 SW_MODE, RW, reset 0.
  - 0x8 INPUT: RO, current sampled i_data.
  - 0xC: unmapped, returns d_error=1 and data 0.
- Reset (i_reset high at a rising edge):
  - All registers, o_data, o_d_valid, o_d_error, o_d_data and o_d_opcode clear to 0.
  - o_a_ready is held 0 while i_reset is high.
- Handshake:
  - Single outstanding transaction; o_a_ready = ~o_d_valid (outside reset).
  - A request is accepted when i_a_valid and o_a_ready are both high on a rising edge.
  - The response is presented the next cycle.
  - o_d_valid and all D fields are held stable until i_d_ready; o_d_valid drops on the edge where i_d_ready is sampled high.
  - A new request may be accepted on the cycle after the D handshake.
- Writes (opcode 0 or 1) return AccessAck with d_data 0.
  - Byte lanes update only where the mask bit is set.
  - LED uses lanes covering LED_W.
  - CTRL uses lane 0 only.
  - A write to INPUT is ignored and sets d_error=1.
- Reads (opcode 4) return AccessAckData; the mask is ignored and unused upper bits read 0.
- Any other opcode returns AccessAck with d_error=1 and no state change.
- o_data update, every cycle:
  - SW_MODE=0: o_data <= sampled i_data, 1-cycle latency without the optional feature.
  - SW_MODE=1: o_data <= LED register.
  - A write to LED while SW_MODE=0 still stores the value; it appears on o_data only after SW_MODE is set.
  - A write that sets SW_MODE affects o_data from the cycle after the write is accepted.
- Reset asserted mid-transaction drops the pending response with no D beat, clears SW_MODE, and returns o_data to 0.

Optional Feature:
- Macro: TLUL_SLAVE_LEDS_INPUT_SYNC_EN.
- Defined: i_data passes through a 2-flop synchronizer (reset 0) before use.
  - Passthrough latency i_data to o_data becomes 3 cycles.
  - INPUT reads the synchronized value.
- Undefined: i_data is sampled directly; passthrough latency is 1 cycle and INPUT reads raw i_data.

Decomposition:
- Package tlul_pkg: A/D opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4, ACCESS_ACK=0, ACCESS_ACK_DATA=1) and register offset constants (LED=0x0, CTRL=0x4, INPUT=0x8).
- One natural sub-module: tlul_slave_leds_sync, the parameterised 2-flop synchronizer used under the macro.

Test Plan:
- Reset held 2 cycles, then released -> o_data=0, o_d_valid=0, and o_a_ready goes 1 the cycle after release.
- Passthrough: drive 10 successive i_data values (e.g. 0x24, 0x81, 0x09) one per cycle -> o_data equals each value 1 cycle later (3 cycles with macro).
- Put LED=0xA5 (mask 0xF), then Get LED -> AccessAck then AccessAckData with d_data=0x000000A5; o_data still tracks i_data.
- Put CTRL=1, then i_data=0xFF -> o_data=0xA5 from the next cycle and unaffected by i_data.
- Get at 0xC, then Put at 0x8 -> d_error=1 on both responses; INPUT value unchanged.
- Hold i_d_ready=0 for 3 cycles after a Get -> o_d_valid and the D fields stay stable, o_a_ready=0; both recover after i_d_ready=1. Assert i_reset during a pending D beat -> o_d_valid=0 and SW_MODE=0.
